// File: rtl/udp_rx_csum_check.sv
// UDP receive checksum checker: one's-complement sum over pseudo-header, UDP header and payload,
// with length consistency, reported two cycles after the last word of each datagram.
module udp_rx_csum_check #(
    parameter logic [7:0] PROTO        = 8'h11,
    parameter bit         REQUIRE_CSUM = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] udp_data,
    input  logic [7:0]  udp_keep,
    input  logic        udp_data_valid,
    input  logic        sop,
    input  logic        eop,
    input  logic [31:0] ip_src,
    input  logic [31:0] ip_dst,
    output logic        csum_valid,
    output logic        csum_ok,
    output logic        csum_absent,
    output logic        len_err
);

    typedef enum logic [0:0] {StIdle, StAcc} state_e;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [16:0] cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic [15:0] fld_q, fld_d;
    logic        fin;

    logic [63:0] data_m;
    logic [17:0] lane_sum;
    logic [18:0] pseudo;
    logic [3:0]  pop;

    // Bytes outside keep are zeroed, which also pads an odd trailing byte.
    always_comb begin
        data_m = '0;
        pop    = '0;
        for (int i = 0; i < 8; i++) begin
            if (udp_keep[7-i]) begin
                data_m[63-8*i -: 8] = udp_data[63-8*i -: 8];
                pop = pop + 4'd1;
            end
        end
    end

    assign lane_sum = 18'(data_m[63:48]) + 18'(data_m[47:32]) +
                      18'(data_m[31:16]) + 18'(data_m[15:0]);
    assign pseudo   = 19'(ip_src[31:16]) + 19'(ip_src[15:0]) +
                      19'(ip_dst[31:16]) + 19'(ip_dst[15:0]) +
                      19'(PROTO) + 19'(data_m[31:16]);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        fld_d   = fld_q;
        fin     = 1'b0;
        if (udp_data_valid) begin
            // A sop in StAcc silently restarts; the partial datagram never reports.
            if (sop) begin
                acc_d   = 32'(lane_sum) + 32'(pseudo);
                cnt_d   = 17'(pop);
                len_d   = data_m[31:16];
                fld_d   = data_m[15:0];
                fin     = eop;
                state_d = eop ? StIdle : StAcc;
            end else if (state_q == StAcc) begin
                acc_d = acc_q + 32'(lane_sum);
                cnt_d = cnt_q + 17'(pop);
                if (eop) begin
                    fin     = 1'b1;
                    state_d = StIdle;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            fld_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            fld_q   <= fld_d;
        end
    end

    // Result pipeline runs independently so a new datagram may start right after eop.
    logic        p1_valid_q;
    logic [16:0] f1_q;
    logic [16:0] cnt1_q;
    logic [15:0] len1_q;
    logic [15:0] fld1_q;
    logic [15:0] f2;
    logic        absent;
    logic        lerr;

    assign f2     = f1_q[15:0] + 16'(f1_q[16]);
    assign absent = (fld1_q == 16'h0000);
    assign lerr   = (cnt1_q != 17'(len1_q)) || (len1_q < 16'd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_q  <= 1'b0;
            f1_q        <= '0;
            cnt1_q      <= '0;
            len1_q      <= '0;
            fld1_q      <= '0;
            csum_valid  <= 1'b0;
            csum_ok     <= 1'b0;
            csum_absent <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            p1_valid_q <= fin;
            if (fin) begin
                f1_q   <= 17'(acc_d[15:0]) + 17'(acc_d[31:16]);
                cnt1_q <= cnt_d;
                len1_q <= len_d;
                fld1_q <= fld_d;
            end
            csum_valid <= p1_valid_q;
            if (p1_valid_q) begin
                csum_absent <= absent;
                len_err     <= lerr;
                csum_ok     <= !lerr && ((f2 == 16'hFFFF) || (absent && !REQUIRE_CSUM));
            end
        end
    end

endmodule
